// File: rtl/babbage_engine_gen_if.sv
// Handshake, config and result bundle for the finite-difference engine.
// master = control side (start/config), slave = engine side.
interface babbage_engine_gen_if #(
    parameter int W  = 20,
    parameter int NW = 6,
    parameter int AW = 2
);
    logic          start;
    logic          stream;
    logic [NW-1:0] n;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [W-1:0]  cfg_data;
    logic          ready;
    logic          busy;
    logic          done_tick;
    logic [W-1:0]  out;
    logic          ovf;
    logic          stream_tick;
    logic [W-1:0]  stream_data;

    modport master (
        output start, stream, n, cfg_we, cfg_addr, cfg_data,
        input  ready, busy, done_tick, out, ovf, stream_tick, stream_data
    );

    modport slave (
        input  start, stream, n, cfg_we, cfg_addr, cfg_data,
        output ready, busy, done_tick, out, ovf, stream_tick, stream_data
    );
endinterface

// File: rtl/babbage_engine_gen.sv
// Runtime-programmable finite-difference engine: f(n) from a loaded difference table, adds only.
// Latency n+2 cycles from accepted start to done_tick; no backpressure, start accepted only while ready.
module babbage_engine_gen #(
    parameter int W     = 20,
    parameter int ORDER = 3,
    parameter int NW    = 6,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    babbage_engine_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  init_q [ORDER+1];
    logic [W-1:0]  d_q    [ORDER+1];
    logic [W:0]    sum_w  [ORDER];
    logic [NW-1:0] cnt;
    logic [NW-1:0] n_reg;
    logic          stream_reg;
    logic [W-1:0]  out_q;
    logic          ovf_q;
    logic          carry_any;
    logic          last;

    // One extra bit per adder exposes the carry-out that feeds the sticky ovf.
    always_comb begin
        sum_w     = '{default: '0};
        carry_any = 1'b0;
        for (int k = 0; k < ORDER; k++) begin
            sum_w[k]  = {1'b0, d_q[k]} + {1'b0, d_q[k+1]};
            carry_any = carry_any | sum_w[k][W];
        end
    end

    assign last = (cnt == n_reg);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = OP;
            OP:      if (last)      state_nxt = DONE;
            DONE:                   state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k <= ORDER; k++) begin
                init_q[k] <= '0;
                d_q[k]    <= '0;
            end
            cnt        <= '0;
            n_reg      <= '0;
            stream_reg <= 1'b0;
            out_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Addresses above ORDER match no entry and are dropped.
                    for (int k = 0; k <= ORDER; k++)
                        if (bus.cfg_we && bus.cfg_addr == AW'(k))
                            init_q[k] <= bus.cfg_data;
                    if (bus.start) begin
                        for (int k = 0; k <= ORDER; k++)
                            d_q[k] <= init_q[k];
                        cnt        <= '0;
                        n_reg      <= bus.n;
                        stream_reg <= bus.stream;
                        ovf_q      <= 1'b0;
                    end
                end
                OP: begin
                    if (last) begin
                        out_q <= d_q[0];
                    end else begin
                        for (int k = 0; k < ORDER; k++)
                            d_q[k] <= sum_w[k][W-1:0];
                        cnt <= cnt + 1'b1;
                        if (carry_any) ovf_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.ready       = (state == IDLE);
    assign bus.busy        = (state == OP) || (state == DONE);
    assign bus.done_tick   = (state == DONE);
    assign bus.out         = out_q;
    assign bus.ovf         = ovf_q;
    assign bus.stream_tick = (state == OP) && stream_reg;
    assign bus.stream_data = d_q[0];
endmodule

// File: tb/tb_babbage_engine_gen.sv
// Directed bench for babbage_engine_gen: hand-computed polynomial values, timing and protocol checks.
module tb_babbage_engine_gen;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    babbage_engine_gen_if #(.W(20), .NW(6), .AW(2)) b ();
    babbage_engine_gen_if #(.W(20), .NW(6), .AW(2)) b2 ();

    babbage_engine_gen #(.W(20), .ORDER(3), .NW(6), .AW(2)) dut (
        .clk(clk), .reset(reset), .bus(b)
    );
    babbage_engine_gen #(.W(20), .ORDER(2), .NW(6), .AW(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2)
    );

    int          lat;
    int          nticks;
    logic [19:0] sdat [8];
    logic [19:0] got_out;
    logic        got_ovf;
    logic        after_tick;
    logic        after_ready;
    logic        ovf_early;
    logic [19:0] mid_out;
    int          extra;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [19:0] a0, a1, a2, a3);
        logic [19:0] v [4];
        v = '{a0, a1, a2, a3};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b.cfg_we = 1'b1; b.cfg_addr = 2'(i); b.cfg_data = v[i];
        end
        @(negedge clk);
        b.cfg_we = 1'b0;
    endtask

    // Starts a run, optionally writing addr 0 alongside start, or poking start/cfg_we mid-op.
    task automatic run(input logic [5:0] nn, input logic s, input logic inject,
                       input logic sim_we, input logic [19:0] sim_data);
        @(negedge clk);
        b.start = 1'b1; b.n = nn; b.stream = s;
        b.cfg_we = sim_we; b.cfg_addr = 2'd0; b.cfg_data = sim_data;
        @(negedge clk);
        b.start = 1'b0; b.cfg_we = 1'b0; b.n = 6'd0; b.stream = 1'b0;
        lat = 1; nticks = 0;
        while (!b.done_tick && lat < 200) begin
            if (lat == 1) ovf_early = b.ovf;
            if (lat == 2) mid_out = b.out;
            if (b.stream_tick) begin
                if (nticks < 8) sdat[nticks] = b.stream_data;
                nticks++;
            end
            if (inject && lat == 2) begin
                b.start = 1'b1; b.cfg_we = 1'b1; b.cfg_addr = 2'd0; b.cfg_data = 20'd7;
            end else begin
                b.start = 1'b0; b.cfg_we = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        b.start = 1'b0; b.cfg_we = 1'b0;
        got_out = b.out;
        got_ovf = b.ovf;
        @(negedge clk);
        after_tick  = b.done_tick;
        after_ready = b.ready;
    endtask

    initial begin
        b.start = 0; b.stream = 0; b.n = 0; b.cfg_we = 0; b.cfg_addr = 0; b.cfg_data = 0;
        b2.start = 0; b2.stream = 0; b2.n = 0; b2.cfg_we = 0; b2.cfg_addr = 0; b2.cfg_data = 0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready", b.ready, 1);
        check("rst_busy", b.busy, 0);
        check("rst_done", b.done_tick, 0);
        check("rst_stick", b.stream_tick, 0);
        check("rst_out", b.out, 0);
        check("rst_ovf", b.ovf, 0);

        // 2n^2+3n+5 at n=3
        load(20'd5, 20'd5, 20'd4, 20'd0);
        run(6'd3, 1'b0, 1'b0, 1'b0, 20'd0);
        check("quad_lat", lat, 5);
        check("quad_out", got_out, 32);
        check("quad_ovf", got_ovf, 0);
        check("quad_noticks", nticks, 0);
        check("quad_onepulse", after_tick, 0);
        check("quad_idle", after_ready, 1);

        // n^3+2n^2+2n streamed
        load(20'd0, 20'd5, 20'd10, 20'd6);
        run(6'd3, 1'b1, 1'b0, 1'b0, 20'd0);
        check("cub_ticks", nticks, 4);
        check("cub_s0", sdat[0], 0);
        check("cub_s1", sdat[1], 5);
        check("cub_s2", sdat[2], 20);
        check("cub_s3", sdat[3], 51);
        check("cub_out", got_out, 51);
        check("cub_lat", lat, 5);

        load(20'h12345, 20'd0, 20'd0, 20'd0);
        run(6'd0, 1'b0, 1'b0, 1'b0, 20'd0);
        check("n0_lat", lat, 2);
        check("n0_out", got_out, 20'h12345);

        load(20'd1, 20'd1, 20'd0, 20'd0);
        run(6'd63, 1'b0, 1'b0, 1'b0, 20'd0);
        check("n63_lat", lat, 65);
        check("n63_out", got_out, 64);
        check("n63_out_held", mid_out, 20'h12345);

        load(20'hFFFFF, 20'd1, 20'd0, 20'd0);
        run(6'd1, 1'b0, 1'b0, 1'b0, 20'd0);
        check("ovf_out", got_out, 0);
        check("ovf_set", got_ovf, 1);

        load(20'd0, 20'd1, 20'd0, 20'd0);
        run(6'd2, 1'b0, 1'b0, 1'b0, 20'd0);
        check("ovf_clr_at_start", ovf_early, 0);
        check("ovf2_out", got_out, 2);
        check("ovf2_flag", got_ovf, 0);

        // start and cfg_we while busy must be ignored
        load(20'd10, 20'd1, 20'd0, 20'd0);
        run(6'd4, 1'b0, 1'b1, 1'b0, 20'd0);
        check("busy_out", got_out, 14);
        check("busy_out_held", mid_out, 2);
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (b.done_tick) extra++;
        end
        check("busy_no_extra_done", extra, 0);
        run(6'd0, 1'b0, 1'b0, 1'b0, 20'd0);
        check("busy_table_kept", got_out, 10);

        // write with start: old value used, new value stored
        run(6'd2, 1'b0, 1'b0, 1'b1, 20'd100);
        check("simwr_old_used", got_out, 12);
        run(6'd0, 1'b0, 1'b0, 1'b0, 20'd0);
        check("simwr_stored", got_out, 100);

        // ORDER=2 instance: addr 3 dropped; init {1,2,3}, n=2 -> 8
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            b2.cfg_we = 1'b1; b2.cfg_addr = 2'(i);
            b2.cfg_data = (i == 3) ? 20'h999 : 20'(i + 1);
        end
        @(negedge clk);
        b2.cfg_we = 1'b0; b2.start = 1'b1; b2.n = 6'd2;
        @(negedge clk);
        b2.start = 1'b0;
        lat = 1;
        while (!b2.done_tick && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("o2_lat", lat, 4);
        check("o2_out", b2.out, 8);
        @(negedge clk);
        b2.start = 1'b1; b2.n = 6'd0;
        @(negedge clk);
        b2.start = 1'b0;
        @(negedge clk);
        check("o2_init0_intact", b2.done_tick, 1);
        check("o2_n0_out", b2.out, 1);

        // async reset mid-op
        load(20'd5, 20'd5, 20'd4, 20'd0);
        @(negedge clk);
        b.start = 1'b1; b.n = 6'd40; b.stream = 1'b1;
        @(negedge clk);
        b.start = 1'b0; b.stream = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", b.busy, 1);
        check("pre_rst_stick", b.stream_tick, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_ready", b.ready, 1);
        check("arst_busy", b.busy, 0);
        check("arst_stick", b.stream_tick, 0);
        check("arst_out", b.out, 0);
        check("arst_sdata", b.stream_data, 0);
        @(negedge clk);
        reset = 1'b0;
        run(6'd5, 1'b0, 1'b0, 1'b0, 20'd0);
        check("post_rst_out", got_out, 0);
        check("post_rst_lat", lat, 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
